// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller, one 32-bit word per line.
// Optional macro CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
`ifdef CACHE_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_fetch,
  output logic              mem_wrt_bck
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, CHECK, WB, FETCH1, FETCH2} state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              req_wr;
  logic              refill;

  logic [LINES-1:0]  valid_arr;
  logic [LINES-1:0]  dirty_arr;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [31:0]       data_arr [LINES];

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_off;
  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_data;
  logic               hit;
  logic               req_valid;
  logic [7:0]         rd_byte;
  logic [31:0]        wr_word;

  assign req_index  = req_addr[INDEX_W+1:2];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_W+2];
  assign req_off    = req_addr[1:0];
  assign line_valid = valid_arr[req_index];
  assign line_dirty = dirty_arr[req_index];
  assign line_tag   = tag_arr[req_index];
  assign line_data  = data_arr[req_index];
  assign hit        = line_valid && (line_tag == req_tag);
  // A request seen while the completion pulse is still high is the one just served.
  assign req_valid  = (cpu_rd || cpu_wr) && !cpu_ready;

  always_comb begin
    rd_byte = line_data[7:0];
    wr_word = line_data;
    case (req_off)
      2'd0: begin rd_byte = line_data[7:0];   wr_word[7:0]   = req_wdata; end
      2'd1: begin rd_byte = line_data[15:8];  wr_word[15:8]  = req_wdata; end
      2'd2: begin rd_byte = line_data[23:16]; wr_word[23:16] = req_wdata; end
      default: begin rd_byte = line_data[31:24]; wr_word[31:24] = req_wdata; end
    endcase
  end

  always_comb begin
    next_state  = state;
    mem_fetch   = 1'b0;
    mem_wrt_bck = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        if (req_valid) next_state = CHECK;
      end
      CHECK: begin
        if (hit)                           next_state = IDLE;
        else if (line_valid && line_dirty) next_state = WB;
        else                               next_state = FETCH1;
      end
      WB: begin
        mem_wrt_bck = 1'b1;
        mem_addr    = {line_tag, req_index, 2'b00};
        mem_wdata   = line_data;
        next_state  = FETCH1;
      end
      FETCH1: begin
        mem_fetch  = 1'b1;
        mem_addr   = {req_addr[ADDR_W-1:2], 2'b00};
        next_state = FETCH2;
      end
      FETCH2: begin
        mem_fetch  = 1'b1;
        mem_addr   = {req_addr[ADDR_W-1:2], 2'b00};
        next_state = CHECK;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
      refill    <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      state     <= next_state;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_wr    <= cpu_wr && !cpu_rd;
            refill    <= 1'b0;
          end
        end
        CHECK: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            if (req_wr) dirty_arr[req_index] <= 1'b1;
            else        cpu_rdata <= rd_byte;
          end
        end
        FETCH2: begin
          valid_arr[req_index] <= 1'b1;
          dirty_arr[req_index] <= 1'b0;
          refill               <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset forces IDLE immediately, so these unreset arrays never update after an abandoned miss.
  always_ff @(posedge clk) begin
    if (state == FETCH2) begin
      tag_arr[req_index]  <= req_tag;
      data_arr[req_index] <= mem_rdata;
    end else if (state == CHECK && hit && req_wr) begin
      data_arr[req_index] <= wr_word;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == CHECK && !refill) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl: latency, lane selection, eviction, reset abort.
// Define CACHE_STATS_EN to also check the hit/miss counters.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_fetch;
  logic        mem_wrt_bck;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  int          r_cycles, r_fetch, r_wb, r_both, r_wb_cyc, r_fetch_cyc;
  logic [7:0]  r_rdata;
  logic [23:0] r_fetch_addr, r_wb_addr;
  logic [31:0] r_wb_data;

  cache_ctrl #(.ADDR_W(24), .INDEX_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_fetch(mem_fetch), .mem_wrt_bck(mem_wrt_bck)
  );

  always #5 clk = ~clk;

  // Issue one request at a falling edge and record every memory strobe until cpu_ready.
  task automatic run_req(input logic rd, input logic wr, input logic [23:0] addr, input logic [7:0] wd);
    bit done = 0;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    r_cycles = 0; r_fetch = 0; r_wb = 0; r_both = 0; r_wb_cyc = 0; r_fetch_cyc = 0;
    r_rdata = 8'h00; r_fetch_addr = 24'h0; r_wb_addr = 24'h0; r_wb_data = 32'h0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_fetch && mem_wrt_bck) r_both++;
      if (mem_fetch) begin
        if (r_fetch == 0) r_fetch_cyc = k;
        r_fetch++; r_fetch_addr = mem_addr;
      end
      if (mem_wrt_bck) begin
        r_wb++; r_wb_cyc = k; r_wb_addr = mem_addr; r_wb_data = mem_wdata;
      end
      if (cpu_ready) begin
        r_cycles = k; r_rdata = cpu_rdata; done = 1;
      end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("[TB] FAIL req_timeout addr=%h got no cpu_ready exp ready within 20 cycles", addr); end
    vectors++;
    if (r_both !== 0) begin miscompares++; $display("[TB] FAIL strobe_overlap got %0d overlapping cycles exp 0", r_both); end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (cpu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_pulse got %b exp 0 one cycle after completion", cpu_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (cpu_ready !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_cpu_ready got %b exp 0", cpu_ready); end
    vectors++; if (cpu_rdata !== 8'h00)  begin miscompares++; $display("[TB] FAIL rst_cpu_rdata got %h exp 00", cpu_rdata); end
    vectors++; if (mem_fetch !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_mem_fetch got %b exp 0", mem_fetch); end
    vectors++; if (mem_wrt_bck !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_wrt_bck got %b exp 0", mem_wrt_bck); end
    vectors++; if (mem_addr !== 24'h0)   begin miscompares++; $display("[TB] FAIL rst_mem_addr got %h exp 000000", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0)  begin miscompares++; $display("[TB] FAIL rst_mem_wdata got %h exp 00000000", mem_wdata); end
`ifdef CACHE_STATS_EN
    vectors++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_counters got %h/%h exp 0000/0000", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_cold_miss();
    mem_rdata = 32'hDDCCBBAA;
    run_req(1'b1, 1'b0, 24'h000104, 8'h00);
    vectors++; if (r_cycles !== 5)            begin miscompares++; $display("[TB] FAIL cold_latency got %0d exp 5", r_cycles); end
    vectors++; if (r_rdata !== 8'hAA)         begin miscompares++; $display("[TB] FAIL cold_rdata got %h exp AA", r_rdata); end
    vectors++; if (r_fetch !== 2)             begin miscompares++; $display("[TB] FAIL cold_fetch_cycles got %0d exp 2", r_fetch); end
    vectors++; if (r_fetch_addr !== 24'h000104) begin miscompares++; $display("[TB] FAIL cold_fetch_addr got %h exp 000104", r_fetch_addr); end
    vectors++; if (r_wb !== 0)                begin miscompares++; $display("[TB] FAIL cold_wb got %0d exp 0", r_wb); end
  endtask

  task automatic test_read_hit();
    mem_rdata = 32'h0;
    run_req(1'b1, 1'b0, 24'h000106, 8'h00);
    vectors++; if (r_cycles !== 2)    begin miscompares++; $display("[TB] FAIL hit_latency got %0d exp 2", r_cycles); end
    vectors++; if (r_rdata !== 8'hCC) begin miscompares++; $display("[TB] FAIL hit_rdata got %h exp CC", r_rdata); end
    vectors++; if (r_fetch + r_wb !== 0) begin miscompares++; $display("[TB] FAIL hit_strobes got %0d exp 0", r_fetch + r_wb); end
  endtask

  task automatic test_write_hit();
    run_req(1'b0, 1'b1, 24'h000105, 8'h55);
    vectors++; if (r_cycles !== 2)       begin miscompares++; $display("[TB] FAIL wr_latency got %0d exp 2", r_cycles); end
    vectors++; if (r_fetch + r_wb !== 0) begin miscompares++; $display("[TB] FAIL wr_strobes got %0d exp 0", r_fetch + r_wb); end
  endtask

  task automatic test_dirty_evict();
    mem_rdata = 32'h11223344;
    run_req(1'b1, 1'b0, 24'h010105, 8'h00);
    vectors++; if (r_cycles !== 6)             begin miscompares++; $display("[TB] FAIL evict_latency got %0d exp 6", r_cycles); end
    vectors++; if (r_wb !== 1)                 begin miscompares++; $display("[TB] FAIL evict_wb_cycles got %0d exp 1", r_wb); end
    vectors++; if (r_wb_cyc !== 2)             begin miscompares++; $display("[TB] FAIL evict_wb_cycle got %0d exp 2", r_wb_cyc); end
    vectors++; if (r_wb_addr !== 24'h000104)   begin miscompares++; $display("[TB] FAIL evict_wb_addr got %h exp 000104", r_wb_addr); end
    vectors++; if (r_wb_data !== 32'hDDCC55AA) begin miscompares++; $display("[TB] FAIL evict_wb_data got %h exp DDCC55AA", r_wb_data); end
    vectors++; if (r_fetch !== 2 || r_fetch_cyc !== 3) begin miscompares++; $display("[TB] FAIL evict_fetch got %0d cycles from %0d exp 2 from 3", r_fetch, r_fetch_cyc); end
    vectors++; if (r_fetch_addr !== 24'h010104) begin miscompares++; $display("[TB] FAIL evict_fetch_addr got %h exp 010104", r_fetch_addr); end
    vectors++; if (r_rdata !== 8'h33)          begin miscompares++; $display("[TB] FAIL evict_rdata got %h exp 33", r_rdata); end
`ifdef CACHE_STATS_EN
    vectors++; if (hit_cnt !== 16'd2)  begin miscompares++; $display("[TB] FAIL stats_hits got %0d exp 2", hit_cnt); end
    vectors++; if (miss_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL stats_misses got %0d exp 2", miss_cnt); end
`endif
    // Refilled line is clean: swapping back must not write back again.
    mem_rdata = 32'hDDCC55AA;
    run_req(1'b1, 1'b0, 24'h000105, 8'h00);
    vectors++; if (r_cycles !== 5 || r_wb !== 0) begin miscompares++; $display("[TB] FAIL refill_clean got latency %0d wb %0d exp 5 and 0", r_cycles, r_wb); end
    vectors++; if (r_rdata !== 8'h55)            begin miscompares++; $display("[TB] FAIL refill_rdata got %h exp 55", r_rdata); end
  endtask

  task automatic test_rd_wr_both();
    mem_rdata = 32'h0;
    run_req(1'b1, 1'b1, 24'h000107, 8'h99);
    vectors++; if (r_cycles !== 2)    begin miscompares++; $display("[TB] FAIL both_latency got %0d exp 2", r_cycles); end
    vectors++; if (r_rdata !== 8'hDD) begin miscompares++; $display("[TB] FAIL both_rdata got %h exp DD", r_rdata); end
    run_req(1'b1, 1'b0, 24'h000107, 8'h00);
    vectors++; if (r_rdata !== 8'hDD) begin miscompares++; $display("[TB] FAIL both_data_kept got %h exp DD", r_rdata); end
    run_req(1'b1, 1'b0, 24'h020104, 8'h00);
    vectors++; if (r_wb !== 0 || r_cycles !== 5) begin miscompares++; $display("[TB] FAIL both_dirty_kept got wb %0d latency %0d exp 0 and 5", r_wb, r_cycles); end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen = 0;
    mem_rdata = 32'hCAFEF00D;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 24'h000200;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_fetch) seen = 1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL abort_fetch_start got no mem_fetch exp fetch within 10 cycles"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (mem_fetch !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_fetch_drop got %b exp 0", mem_fetch); end
    vectors++; if (mem_addr !== 24'h0) begin miscompares++; $display("[TB] FAIL abort_addr got %h exp 000000", mem_addr); end
    cpu_rd = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ready got %b exp 0", cpu_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (cpu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ready_after got %b exp 0", cpu_ready); end
    run_req(1'b1, 1'b0, 24'h000200, 8'h00);
    vectors++; if (r_cycles !== 5 || r_fetch !== 2) begin miscompares++; $display("[TB] FAIL reread_miss got latency %0d fetch %0d exp 5 and 2", r_cycles, r_fetch); end
    vectors++; if (r_rdata !== 8'h0D) begin miscompares++; $display("[TB] FAIL reread_rdata got %h exp 0D", r_rdata); end
    mem_rdata = 32'hDDCC55AA;
    run_req(1'b1, 1'b0, 24'h000105, 8'h00);
    vectors++; if (r_cycles !== 5 || r_wb !== 0) begin miscompares++; $display("[TB] FAIL reset_invalidate got latency %0d wb %0d exp 5 and 0", r_cycles, r_wb); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_rd_wr_both();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
